// File: rtl/sram_pp_pkg.sv
// Shared types and defaults for the SRAM ping-pong frame controller.
// Half-state encodings and the half-depth derivation live here.
package sram_pp_pkg;

  typedef enum logic [1:0] {
    HS_EMPTY = 2'd0,
    HS_FILL  = 2'd1,
    HS_FULL  = 2'd2,
    HS_DRAIN = 2'd3
  } half_st_e;

  localparam int ADDR_W_DEF = 6;

  function automatic int half_depth(input int aw);
    return 1 << (aw - 1);
  endfunction

  localparam int HALF_DEPTH_DEF = half_depth(ADDR_W_DEF);

endpackage

// File: rtl/sram_pp_rd_pipe.sv
// Read side of the ping-pong controller: issue decision, QB valid/last
// registers and stall hold. SRAM_PP_REVERSE_READ_EN reverses frame order.
module sram_pp_rd_pipe
  import sram_pp_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int HALF_DEPTH = half_depth(ADDR_W)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [1:0]        half_rdy,
  input  logic              out_ready,
  output logic              rd_fire,
  output logic              rd_half,
  output logic              rd_done,
  output logic              sram_cenb,
  output logic [ADDR_W-1:0] sram_ab,
  output logic              out_valid,
  output logic              out_last
);

  localparam int CW = ADDR_W - 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_DEPTH - 1);

  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] rd_addr;

  // QB only advances when the current word is gone or leaving now
  assign rd_fire = half_rdy[rd_half] && (!out_valid || out_ready);
  assign rd_done = rd_fire && (rd_cnt == LAST);

`ifdef SRAM_PP_REVERSE_READ_EN
  assign rd_addr = LAST - rd_cnt;
`else
  assign rd_addr = rd_cnt;
`endif

  assign sram_cenb = !rd_fire;
  assign sram_ab   = rd_fire ? {rd_half, rd_addr} : '0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_cnt  <= '0;
      rd_half <= 1'b0;
    end else if (rd_fire) begin
      if (rd_done) begin
        rd_cnt  <= '0;
        rd_half <= !rd_half;
      end else begin
        rd_cnt  <= rd_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (rd_fire) begin
      out_valid <= 1'b1;
      out_last  <= (rd_cnt == LAST);
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/sram_pingpong_ctrl.sv
// Ping-pong sequencer for a 2-half dual-port SRAM frame buffer.
// Optional macro SRAM_PP_REVERSE_READ_EN reads each frame backwards.
module sram_pingpong_ctrl
  import sram_pp_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int HALF_DEPTH = half_depth(ADDR_W)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              sram_cena,
  output logic [ADDR_W-1:0] sram_aa,
  output logic              sram_cenb,
  output logic [ADDR_W-1:0] sram_ab,
  output logic [1:0]        half_full
);

  localparam int CW = ADDR_W - 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_DEPTH - 1);

  half_st_e      st_q [2];
  half_st_e      st_d [2];
  logic          live;
  logic          wr_half;
  logic [CW-1:0] wr_cnt;
  logic          wr_fire;
  logic          wr_done;
  logic          rd_fire;
  logic          rd_half;
  logic          rd_done;

  // live keeps in_ready low while reset is held
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st_q[0] <= HS_EMPTY;
      st_q[1] <= HS_EMPTY;
      live    <= 1'b0;
      wr_half <= 1'b0;
      wr_cnt  <= '0;
    end else begin
      st_q[0] <= st_d[0];
      st_q[1] <= st_d[1];
      live    <= 1'b1;
      if (wr_fire) begin
        if (wr_done) begin
          wr_cnt  <= '0;
          wr_half <= !wr_half;
        end else begin
          wr_cnt  <= wr_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int h = 0; h < 2; h++) begin
      st_d[h] = st_q[h];
      if (wr_fire && wr_half == 1'(h))
        st_d[h] = wr_done ? HS_FULL : HS_FILL;
      if (rd_fire && rd_half == 1'(h))
        st_d[h] = rd_done ? HS_EMPTY : HS_DRAIN;
    end
  end

  always_comb begin
    for (int h = 0; h < 2; h++)
      half_full[h] = (st_q[h] == HS_FULL) || (st_q[h] == HS_DRAIN);
    in_ready  = live && ((st_q[wr_half] == HS_EMPTY) ||
                         (st_q[wr_half] == HS_FILL));
    wr_fire   = in_valid && in_ready;
    wr_done   = wr_fire && (wr_cnt == LAST);
    sram_cena = !wr_fire;
    sram_aa   = wr_fire ? {wr_half, wr_cnt} : '0;
  end

  sram_pp_rd_pipe #(
    .ADDR_W     (ADDR_W),
    .HALF_DEPTH (HALF_DEPTH)
  ) u_rd (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .half_rdy  (half_full),
    .out_ready (out_ready),
    .rd_fire   (rd_fire),
    .rd_half   (rd_half),
    .rd_done   (rd_done),
    .sram_cenb (sram_cenb),
    .sram_ab   (sram_ab),
    .out_valid (out_valid),
    .out_last  (out_last)
  );

`ifndef SYNTHESIS
  a_no_collide: assert property (@(posedge CLK) disable iff (!RST_N)
    !(wr_fire && rd_fire && (wr_half == rd_half)));
`endif

endmodule

// File: tb/tb_sram_pingpong_ctrl.sv
// Scoreboard bench for sram_pingpong_ctrl with a behavioural SRAM model.
// Honours SRAM_PP_REVERSE_READ_EN when the design is built with it.
module tb_sram_pingpong_ctrl;

  localparam int AW = 6;

`ifdef SRAM_PP_REVERSE_READ_EN
  localparam int FIRST_AB = 31;
`else
  localparam int FIRST_AB = 0;
`endif

  typedef struct packed {
    logic [15:0] d;
    logic        last;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic          sram_cena;
  logic [AW-1:0] sram_aa;
  logic          sram_cenb;
  logic [AW-1:0] sram_ab;
  logic [1:0]    half_full;

  logic [15:0] mem [64];
  logic [15:0] qb;
  logic [15:0] wdata = '0;

  exp_t        sb [$];
  logic [15:0] stage [$];
  exp_t        e;

  int nchk = 0, nerr = 0;
  int cyc = 0, tag = 0;
  int wh, wc, rc, accepts, issues, pops;
  int first_iss, first_ab, last_acc, fa;
  int hf_after;
  bit hfp, ovp, coincide, acc, iss;

  sram_pingpong_ctrl u_dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .sram_cena (sram_cena),
    .sram_aa   (sram_aa),
    .sram_cenb (sram_cenb),
    .sram_ab   (sram_ab),
    .half_full (half_full)
  );

  initial forever #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (!sram_cena) mem[sram_aa] <= wdata;
    if (!sram_cenb) qb <= mem[sram_ab];
  end

  task automatic chk(input string tag_s, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag_s, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    cyc++;
    if (RST_N) begin
      if (hfp) begin
        hf_after = 32'(half_full);
        hfp = 0;
      end
      if (ovp) begin
        chk("ov_rise", 32'(out_valid), 1);
        ovp = 0;
      end
      acc = in_valid && in_ready;
      iss = !sram_cenb;
      if (acc && iss && wc == 31 && rc == 31) coincide = 1;
      if (acc) begin
        chk("cena", 32'(sram_cena), 0);
        chk("aa", 32'(sram_aa), 32'(wh * 32 + wc));
        if (fa < 0) fa = 32'(sram_aa);
`ifdef SRAM_PP_REVERSE_READ_EN
        stage.push_back(wdata);
        if (wc == 31) begin
          for (int i = 31; i >= 0; i--)
            sb.push_back(exp_t'{d: stage[i], last: (i == 0)});
          stage.delete();
        end
`else
        sb.push_back(exp_t'{d: wdata, last: (wc == 31)});
`endif
        if (wc == 31) begin
          wc = 0;
          wh ^= 1;
          hfp = 1;
        end else begin
          wc++;
        end
        accepts++;
        tag++;
        last_acc = cyc;
      end else begin
        chk("cena_idle", 32'(sram_cena), 1);
      end
      if (iss) begin
        chk("cenb_ok", 32'(!out_valid || out_ready), 1);
        if (first_iss < 0) begin
          first_iss = cyc;
          first_ab = 32'(sram_ab);
          ovp = 1;
        end
        rc = (rc == 31) ? 0 : rc + 1;
        issues++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("qb", 32'(qb), 32'(e.d));
          chk("last", 32'(out_last), 32'(e.last));
        end
        pops++;
      end
    end
  end

  task automatic chk_rst();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_cena", 32'(sram_cena), 1);
    chk("rst_cenb", 32'(sram_cenb), 1);
    chk("rst_aa", 32'(sram_aa), 0);
    chk("rst_ab", 32'(sram_ab), 0);
    chk("rst_half_full", 32'(half_full), 0);
  endtask

  task automatic do_reset(input bit check);
    in_valid = 1'b0;
    RST_N = 1'b0;
    #2;
    if (check) chk_rst();
    sb.delete();
    stage.delete();
    wh = 0; wc = 0; rc = 0;
    accepts = 0; issues = 0; pops = 0;
    first_iss = -1; first_ab = -1; last_acc = -1; fa = -1;
    hf_after = -1; hfp = 0; ovp = 0; coincide = 0;
    repeat (2) @(posedge CLK);
    #3 RST_N = 1'b1;
  endtask

  // mode 0: consumer always ready, 1: ready toggles, 2: never ready
  task automatic run(input int tgt, input int mode, input bit drain,
                     input int maxc);
    int n;
    bit done;
    n = 0;
    done = 0;
    while (!done && n < maxc) begin
      @(posedge CLK);
      #1;
      in_valid = (accepts < tgt);
      wdata = 16'(tag);
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = n[0];
        default: out_ready = 1'b0;
      endcase
      n++;
      done = (accepts >= tgt) &&
             (!drain || (sb.size() == 0 && stage.size() == 0 && !out_valid));
    end
    if (mode != 2) chk("run_timeout", 32'(done), 1);
  endtask

  initial begin
    #1;
    do_reset(1);

    // single frame, consumer always ready
    run(32, 0, 1, 200);
    chk("a_accepts", 32'(accepts), 32);
    chk("a_hf_after_fill", 32'(hf_after), 1);
    chk("a_issue_lat", 32'(first_iss - last_acc), 1);
    chk("a_first_ab", 32'(first_ab), FIRST_AB);
    chk("a_pops", 32'(pops), 32);
    chk("a_hf_end", 32'(half_full), 0);

    // consumer stalled: both halves fill, one read outstanding
    do_reset(0);
    run(100, 2, 0, 80);
    chk("b_accepts", 32'(accepts), 64);
    chk("b_in_ready", 32'(in_ready), 0);
    chk("b_half_full", 32'(half_full), 3);
    chk("b_issues", 32'(issues), 1);
    chk("b_out_valid", 32'(out_valid), 1);
    chk("b_qb_held", 32'(qb), 32'(sb[0].d));
    run(64, 0, 1, 400);
    chk("b_pops", 32'(pops), 64);
    chk("b_hf_end", 32'(half_full), 0);

    // throttled consumer
    do_reset(0);
    run(32, 1, 1, 400);
    chk("c_issues", 32'(issues), 32);
    chk("c_pops", 32'(pops), 32);

    // write of half 1 word 31 meets read of half 0 word 31
    do_reset(0);
    run(64, 0, 1, 400);
    chk("d_coincide", 32'(coincide), 1);
    chk("d_hf_after", 32'(hf_after), 2);
    chk("d_pops", 32'(pops), 64);

    // reset in the middle of a frame
    do_reset(0);
    run(10, 0, 0, 50);
    chk("e_accepts", 32'(accepts), 10);
    do_reset(1);
    repeat (3) @(posedge CLK);
    #1;
    chk("e_hf", 32'(half_full), 0);
    chk("e_out_valid", 32'(out_valid), 0);
    chk("e_cenb", 32'(sram_cenb), 1);
    chk("e_in_ready", 32'(in_ready), 1);
    run(1, 0, 0, 20);
    chk("e_aa_restart", 32'(fa), 0);

    @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
